attribute_writer: RTL and testbench



---
 rtl/attribute_writer.sv | 208 ++++++++++++++++++++
 tb/tb_attribute_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/attribute_writer.sv
// rtl/attribute_writer.sv - serialises one XML attribute (name="value") into an ASCII stream
// Optional feature macro: ATTRIBUTE_WRITER_QUOTES_EN wraps the decimal value in double quotes.
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef ATT_COLOR
`define ATT_COLOR    4'd1
`define ATT_SIZE     4'd2
`define ATT_WIDTH    4'd3
`define ATT_HEIGHT   4'd4
`define ATT_SRC      4'd5
`define ATT_HREF     4'd6
`define ATT_BG       4'd7
`define ATT_PADDING  4'd8
`define ATT_MARGIN   4'd9
`define ATT_BORDER   4'd10
`define ATT_POSITION 4'd11
`endif

module attribute_writer #(
   parameter int VAL_BITS = 16,
   parameter int DIGITS   = 5
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic [`ATTRIBUTE_TYPE_BITES-1:0] in_type,
   input  logic [VAL_BITS-1:0]              in_value,
   output logic [`CHAR_BITES-1:0]           char,
   output logic                             char_valid,
   input  logic                             char_ready,
   output logic                             busy,
   output logic                             has_finished,
   output logic                             bad_type
);
   localparam int CNT_W = $clog2(VAL_BITS + 1);
   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BCD_W = 4 * DIGITS;
`ifdef ATTRIBUTE_WRITER_QUOTES_EN
   localparam bit QUOTES = 1'b1;
`else
   localparam bit QUOTES = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_CONVERT, ST_NAME, ST_EQUALS, ST_OPEN_Q, ST_DIGITS, ST_CLOSE_Q, ST_DONE
   } state_t;

   // Names are right-justified in 80 bits; character i of an L-long name sits at byte L-1-i.
   function automatic logic [79:0] name_str(input logic [`ATTRIBUTE_TYPE_BITES-1:0] t);
      case (t)
         `ATT_COLOR:    name_str = 80'("color");
         `ATT_SIZE:     name_str = 80'("size");
         `ATT_WIDTH:    name_str = 80'("width");
         `ATT_HEIGHT:   name_str = 80'("height");
         `ATT_SRC:      name_str = 80'("src");
         `ATT_HREF:     name_str = 80'("href");
         `ATT_BG:       name_str = 80'("background");
         `ATT_PADDING:  name_str = 80'("padding");
         `ATT_MARGIN:   name_str = 80'("margin");
         `ATT_BORDER:   name_str = 80'("border");
         `ATT_POSITION: name_str = 80'("position");
         default:       name_str = '0;
      endcase
   endfunction

   function automatic logic [3:0] name_len(input logic [`ATTRIBUTE_TYPE_BITES-1:0] t);
      case (t)
         `ATT_COLOR, `ATT_WIDTH:                name_len = 4'd5;
         `ATT_SIZE, `ATT_HREF:                  name_len = 4'd4;
         `ATT_HEIGHT, `ATT_MARGIN, `ATT_BORDER: name_len = 4'd6;
         `ATT_SRC:                              name_len = 4'd3;
         `ATT_BG:                               name_len = 4'd10;
         `ATT_PADDING:                          name_len = 4'd7;
         `ATT_POSITION:                         name_len = 4'd8;
         default:                               name_len = 4'd0;
      endcase
   endfunction

   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
      dabble_adjust = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) dabble_adjust[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
   endfunction

   state_t                            state, state_d;
   logic [`ATTRIBUTE_TYPE_BITES-1:0]  type_q;
   logic                              bad_q;
   logic [VAL_BITS-1:0]               bin_q;
   logic [BCD_W-1:0]                  bcd_q;
   logic [CNT_W-1:0]                  cnt_q;
   logic [PTR_W-1:0]                  ptr_q;
   logic [3:0]                        idx_q;
   logic [3:0]                        name_l;
   logic [3:0]                        name_rev;
   logic [79:0]                       name_shift;
   logic [BCD_W-1:0]                  bcd_shift;
   logic [PTR_W-1:0]                  msd;

   always_comb begin
      name_l     = name_len(type_q);
      name_rev   = name_l - 4'd1 - idx_q;
      name_shift = name_str(type_q) >> (8 * name_rev);
      bcd_shift  = bcd_q >> (4 * ptr_q);
      msd        = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = PTR_W'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d      = state;
      char         = '0;
      char_valid   = 1'b0;
      busy         = (state != ST_IDLE);
      has_finished = 1'b0;
      bad_type     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_d = (name_len(in_type) != 4'd0) ? ST_CONVERT : ST_DONE;
         end
         ST_CONVERT: begin
            if (cnt_q == CNT_W'(VAL_BITS)) state_d = ST_NAME;
         end
         ST_NAME: begin
            char_valid = 1'b1;
            char       = `CHAR_BITES'(name_shift[7:0]);
            if (char_ready && idx_q == name_l - 4'd1) state_d = ST_EQUALS;
         end
         ST_EQUALS: begin
            char_valid = 1'b1;
            char       = `CHAR_BITES'(8'h3d);
            if (char_ready) state_d = QUOTES ? ST_OPEN_Q : ST_DIGITS;
         end
         ST_OPEN_Q: begin
            char_valid = 1'b1;
            char       = `CHAR_BITES'(8'h22);
            if (char_ready) state_d = ST_DIGITS;
         end
         ST_DIGITS: begin
            char_valid = 1'b1;
            char       = `CHAR_BITES'(8'h30 + {4'h0, bcd_shift[3:0]});
            if (char_ready && ptr_q == '0) state_d = QUOTES ? ST_CLOSE_Q : ST_DONE;
         end
         ST_CLOSE_Q: begin
            char_valid = 1'b1;
            char       = `CHAR_BITES'(8'h22);
            if (char_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            has_finished = 1'b1;
            bad_type     = bad_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch on start, shift-and-adjust during CONVERT, walk name/digit pointers on transfers.
   always_ff @(posedge clock) begin
      if (reset) begin
         type_q <= '0;
         bad_q  <= 1'b0;
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         ptr_q  <= '0;
         idx_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  type_q <= in_type;
                  bad_q  <= (name_len(in_type) == 4'd0);
                  bin_q  <= in_value;
                  bcd_q  <= '0;
                  cnt_q  <= '0;
                  idx_q  <= '0;
               end
            end
            ST_CONVERT: begin
               if (cnt_q != CNT_W'(VAL_BITS)) begin
                  {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
                  cnt_q          <= cnt_q + 1'b1;
               end else begin
                  ptr_q <= msd;
               end
            end
            ST_NAME: begin
               if (char_ready) idx_q <= idx_q + 4'd1;
            end
            ST_DIGITS: begin
               if (char_ready && ptr_q != '0) ptr_q <= ptr_q - 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_attribute_writer.sv
// tb/tb_attribute_writer.sv - directed and randomized self-checking bench for attribute_writer
// Expected streams are built from the name table and the decimal value with $sformatf.
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif
`ifndef ATT_COLOR
`define ATT_COLOR    4'd1
`define ATT_SIZE     4'd2
`define ATT_WIDTH    4'd3
`define ATT_HEIGHT   4'd4
`define ATT_SRC      4'd5
`define ATT_HREF     4'd6
`define ATT_BG       4'd7
`define ATT_PADDING  4'd8
`define ATT_MARGIN   4'd9
`define ATT_BORDER   4'd10
`define ATT_POSITION 4'd11
`endif

module tb_attribute_writer;
   localparam int VB = 16;
   localparam int DG = 5;

   logic                             clock = 1'b0;
   logic                             reset;
   logic                             start;
   logic [`ATTRIBUTE_TYPE_BITES-1:0] in_type;
   logic [VB-1:0]                    in_value;
   logic [`CHAR_BITES-1:0]           char;
   logic                             char_valid;
   logic                             char_ready;
   logic                             busy;
   logic                             has_finished;
   logic                             bad_type;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   attribute_writer #(.VAL_BITS(VB), .DIGITS(DG)) dut (
      .clock(clock), .reset(reset), .start(start), .in_type(in_type), .in_value(in_value),
      .char(char), .char_valid(char_valid), .char_ready(char_ready),
      .busy(busy), .has_finished(has_finished), .bad_type(bad_type)
   );

   function automatic string name_of(input logic [`ATTRIBUTE_TYPE_BITES-1:0] t);
      case (t)
         `ATT_COLOR:    return "color";
         `ATT_SIZE:     return "size";
         `ATT_WIDTH:    return "width";
         `ATT_HEIGHT:   return "height";
         `ATT_SRC:      return "src";
         `ATT_HREF:     return "href";
         `ATT_BG:       return "background";
         `ATT_PADDING:  return "padding";
         `ATT_MARGIN:   return "margin";
         `ATT_BORDER:   return "border";
         `ATT_POSITION: return "position";
         default:       return "";
      endcase
   endfunction

   function automatic string expect_str(input logic [`ATTRIBUTE_TYPE_BITES-1:0] t, input int unsigned v);
      if (name_of(t).len() == 0) return "";
`ifdef ATTRIBUTE_WRITER_QUOTES_EN
      return $sformatf("%s=\"%0d\"", name_of(t), v);
`else
      return $sformatf("%s=%0d", name_of(t), v);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
   task automatic send(input logic [`ATTRIBUTE_TYPE_BITES-1:0] t, input logic [VB-1:0] v,
                       input int mode, input bit disturb, input bit abort);
      string exp_s, got;
      int fin_cnt, fin_k, first_k, last_k, nxfer, abort_at, bad_seen, valid_seen;
      logic prev_valid, prev_ready;
      logic [`CHAR_BITES-1:0] prev_char;
      bit rdy, ok_type;
      exp_s = expect_str(t, v);
      ok_type = (exp_s.len() > 0);
      got = "";
      fin_cnt = 0; fin_k = -1; first_k = -1; last_k = -1; nxfer = 0;
      bad_seen = 0; valid_seen = 0; prev_valid = 0; prev_ready = 0; prev_char = '0;
`ifdef ATTRIBUTE_WRITER_QUOTES_EN
      abort_at = name_of(t).len() + 3;
`else
      abort_at = name_of(t).len() + 2;
`endif
      @(negedge clock);
      check("idle_before_start", busy, 0);
      start = 1; in_type = t; in_value = v; char_ready = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         if (k == 0) begin
            start = 0;
            check("busy_after_start", busy, 1);
         end
         if (disturb && (k == 3 || k == 20)) begin
            start = 1; in_type = `ATT_SRC; in_value = v + 16'd1;
         end
         if (disturb && (k == 4 || k == 21)) begin
            start = 0; in_value = ~v;
         end
         if (prev_valid && !prev_ready) begin
            check("stall_char", char, prev_char);
            check("stall_valid", char_valid, 1);
         end
         if (char_valid && first_k < 0) first_k = k;
         if (char_valid) valid_seen++;
         if (bad_type && !has_finished) bad_seen++;
         if (fin_k >= 0 && k == fin_k + 1) begin
            check("busy_low_after_done", busy, 0);
            start = 0;
         end
         if (fin_k >= 0 && k == fin_k + 2) begin
            check("start_in_done_ignored", busy, 0);
            break;
         end
         if (has_finished) begin
            fin_cnt++;
            if (fin_k < 0) begin
               fin_k = k;
               check("valid_in_done", char_valid, 0);
               check("bad_flag", bad_type, !ok_type);
               if (disturb) begin
                  start = 1; in_type = `ATT_WIDTH;
               end
            end
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (k % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         char_ready = rdy;
         if (char_valid && rdy) begin
            got = $sformatf("%s%c", got, char);
            nxfer++;
            last_k = k;
         end
         prev_valid = char_valid; prev_ready = rdy; prev_char = char;
         if (abort && nxfer == abort_at) begin
            reset = 1;
            @(negedge clock);
            check("abort_valid", char_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_char", char, 0);
            check("abort_finish", has_finished, 0);
            reset = 0; char_ready = 0;
            @(negedge clock);
            check("abort_no_finish_later", has_finished, 0);
            check("abort_still_idle", busy, 0);
            return;
         end
      end
      check("timeout", fin_k >= 0, 1);
      check("finish_count", fin_cnt, 1);
      check("bad_only_with_finish", bad_seen, 0);
      checks++;
      assert (got == exp_s) else begin
         failures++;
         $error("FAIL stream observed=\"%s\" expected=\"%s\"", got, exp_s);
      end
      if (ok_type) begin
         check("first_valid_latency", first_k, VB + 1);
         check("finish_after_last", fin_k, last_k + 1);
         if (mode == 0) check("finish_latency", fin_k, VB + 1 + exp_s.len());
      end else begin
         check("bad_finish_latency", fin_k, 0);
         check("bad_no_valid", valid_seen, 0);
      end
   endtask

   initial begin
      reset = 1; start = 0; in_type = '0; in_value = '0; char_ready = 0;
      repeat (3) @(negedge clock);
      check("reset_char", char, 0);
      check("reset_valid", char_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_finished", has_finished, 0);
      check("reset_bad", bad_type, 0);
      reset = 0;

      send(`ATT_WIDTH, 16'd120, 0, 1'b0, 1'b0);
      send(`ATT_SRC, 16'd0, 0, 1'b0, 1'b0);
      send(`ATT_BG, 16'd65535, 0, 1'b0, 1'b0);
      send(`ATT_HEIGHT, 16'd7, 1, 1'b0, 1'b0);
      send(4'd0, 16'd55, 0, 1'b0, 1'b0);
      send(4'd13, 16'd9, 0, 1'b0, 1'b0);
      send(`ATT_MARGIN, 16'd300, 0, 1'b0, 1'b1);
      send(`ATT_MARGIN, 16'd300, 0, 1'b0, 1'b0);
      send(`ATT_WIDTH, 16'd120, 0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send(4'($urandom_range(1, 11)), 16'($urandom), 2, 1'(i % 2), 1'b0);
      end
      send(4'($urandom_range(12, 15)), 16'($urandom), 2, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
